// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer.
// Owns the fetch PC, issues in-order word reads under a credit limit, buffers
// returned words with their PCs, and discards stale responses after a redirect.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  input  logic        if_ready
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          req_valid_q, req_valid_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wr_q, rd_q, tag_wr_q, tag_rd_q;
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [31:0]   inst_mem [FIFO_DEPTH];
  logic [31:0]   tag_mem  [FIFO_DEPTH];

  logic          acc, held, run_now, push, pop, tag_push, credit;
  logic [31:0]   redir_pc, pc_src;

  // A request still waiting for ready at the end of this cycle is "held"; it
  // keeps its address even across a redirect and is then treated as stale.
  assign acc      = req_valid_q & mem_req_ready;
  assign held     = req_valid_q & ~mem_req_ready;
  assign run_now  = (state_q == RUN) & ~redirect_valid;
  assign push     = mem_rsp_valid & run_now;
  assign tag_push = acc & run_now;
  assign pop      = (cnt_q != '0) & if_ready & ~redirect_valid;
  assign redir_pc = redirect_pc & ~32'h3;

  // Outstanding-read, drop and buffer-occupancy counters
  always_comb begin
    out_d = out_q + CW'(acc) - CW'(mem_rsp_valid);
    cnt_d = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    if (redirect_valid)
      drop_d = out_d;
    else if (state_q == DRAIN)
      drop_d = drop_q + CW'(acc) - CW'(mem_rsp_valid);
    else
      drop_d = '0;
  end

  // Next-state logic: stay in DRAIN until every stale read has come back
  always_comb begin
    state_d = state_q;
    if (redirect_valid)
      state_d = ((out_d != '0) || held) ? DRAIN : RUN;
    else if ((state_q == DRAIN) && (drop_d == '0) && !held)
      state_d = RUN;
  end

  // Request generation: credit is judged on the counts the new request will see
  always_comb begin
    pc_src      = redirect_valid ? redir_pc : pc_q;
    credit      = ({1'b0, out_d} + {1'b0, cnt_d}) < DEPTH_C;
    req_valid_d = 1'b0;
    req_addr_d  = req_addr_q;
    pc_d        = pc_src;
    if (held) begin
      req_valid_d = 1'b1;
    end else if ((state_d == RUN) && credit) begin
      req_valid_d = 1'b1;
      req_addr_d  = pc_src;
      pc_d        = pc_src + 32'd4;
    end
  end

  // Outputs: head fields read as zero whenever the buffer is empty
  always_comb begin
    mem_req_valid = req_valid_q;
    mem_req_addr  = req_addr_q;
    if_valid      = (cnt_q != '0);
    if_pc         = (cnt_q != '0) ? pc_mem[rd_q]   : '0;
    if_inst       = (cnt_q != '0) ? inst_mem[rd_q] : '0;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Control registers; a redirect flushes the instruction buffer and tag queue
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      pc_q        <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      cnt_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      if (redirect_valid) begin
        wr_q     <= '0;
        rd_q     <= '0;
        tag_wr_q <= '0;
        tag_rd_q <= '0;
      end else begin
        if (push)     wr_q     <= wr_q + PW'(1);
        if (pop)      rd_q     <= rd_q + PW'(1);
        if (tag_push) tag_wr_q <= tag_wr_q + PW'(1);
        if (push)     tag_rd_q <= tag_rd_q + PW'(1);
      end
    end
  end

  // Data storage: request address, tag queue and instruction buffer
  always_ff @(posedge clk) begin
    req_addr_q <= req_addr_d;
    if (tag_push) tag_mem[tag_wr_q] <= req_addr_q;
    if (push) begin
      pc_mem[wr_q]   <= tag_mem[tag_rd_q];
      inst_mem[wr_q] <= mem_rsp_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed bench for imem_fetch_ctrl with a fixed-latency
// in-order memory model returning ~addr as the instruction word.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int mem_lat = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] acc_q[$];
  int          acc_cyc[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_inst[$];

  imem_fetch_ctrl #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_ready(if_ready)
  );

  always #5 clk = ~clk;

  // Memory: accepts on the edge, answers mem_lat edges later, in order
  always @(posedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
      mem_rsp_valid <= 1'b0;
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend_addr.push_back(mem_req_addr);
        pend_due.push_back(cyc + mem_lat - 1);
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= ~pend_addr[0];
        pend_addr.pop_front();
        pend_due.pop_front();
      end else if (mem_req_valid && mem_req_ready && mem_lat == 1) begin
        mem_rsp_valid <= 1'b1;
        mem_rsp_data  <= ~mem_req_addr;
        pend_addr.pop_back();
        pend_due.pop_back();
      end else begin
        mem_rsp_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  // Monitor: log accepted requests and consumed instructions mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req_valid && mem_req_ready) begin
        acc_q.push_back(mem_req_addr);
        acc_cyc.push_back(cyc);
      end
      if (if_valid && if_ready) begin
        pop_pc.push_back(if_pc);
        pop_inst.push_back(if_inst);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete();
    acc_cyc.delete();
    pop_pc.delete();
    pop_inst.delete();
  endtask

  task automatic do_reset(input int lat, input logic rdy, input logic ifr);
    rst = 1'b1;
    redirect_valid = 1'b0;
    mem_lat = lat;
    mem_req_ready = rdy;
    if_ready = ifr;
    step();
    step();
    clear_logs();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h want 00000000", if_pc); end
    n_cmp++; if (if_inst !== 32'h0) begin n_fail++; $display("FAIL reset_if_inst: got %h want 00000000", if_inst); end
  endtask

  task automatic test_stream();
    int first_acc = -1;
    int first_iv = -1;
    do_reset(1, 1'b1, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (first_acc < 0 && mem_req_valid && mem_req_ready) first_acc = i;
      if (first_iv < 0 && if_valid) first_iv = i;
    end
    n_cmp++; if (first_iv - first_acc !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", first_iv - first_acc); end
    n_cmp++; if (pop_pc.size() < 6) begin n_fail++; $display("FAIL stream_count: got %0d want >=6", pop_pc.size()); end
    for (int k = 0; k < 6 && k < pop_pc.size(); k++) begin
      n_cmp++; if (pop_pc[k] !== 32'(4 * k)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, pop_pc[k], 32'(4 * k)); end
      n_cmp++; if (pop_inst[k] !== ~32'(4 * k)) begin n_fail++; $display("FAIL stream_inst[%0d]: got %h want %h", k, pop_inst[k], ~32'(4 * k)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1, 1'b1, 1'b0);
    repeat (4) step();
    n_cmp++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", acc_q.size()); end
    if (acc_q.size() >= 2) begin
      n_cmp++; if (acc_cyc[1] - acc_cyc[0] !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d want 1", acc_cyc[1] - acc_cyc[0]); end
      n_cmp++; if (acc_q[1] !== 32'h4) begin n_fail++; $display("FAIL b2b_addr: got %h want 00000004", acc_q[1]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset(1, 1'b1, 1'b0);
    repeat (10) step();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL bp_if_valid: got %b want 1", if_valid); end
    n_cmp++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 00000000", if_pc); end
    n_cmp++; if (if_inst !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL bp_head_inst: got %h want ffffffff", if_inst); end
    n_cmp++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", acc_q.size()); end
    if_ready = 1'b1;
    repeat (12) step();
    n_cmp++; if (pop_pc.size() < 4) begin n_fail++; $display("FAIL bp_release_count: got %0d want >=4", pop_pc.size()); end
    for (int k = 0; k < 4 && k < pop_pc.size(); k++) begin
      n_cmp++; if (pop_pc[k] !== exp_pc[k]) begin n_fail++; $display("FAIL bp_release_pc[%0d]: got %h want %h", k, pop_pc[k], exp_pc[k]); end
    end
  endtask

  task automatic test_redirect();
    do_reset(3, 1'b1, 1'b1);
    repeat (3) step();
    n_cmp++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL redir_inflight: got %0d want 2", acc_q.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0104;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_if_valid_a: got %b want 0", if_valid); end
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_no_req: got %b want 0", mem_req_valid); end
    step();
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir_if_valid_b: got %b want 0", if_valid); end
    repeat (20) step();
    n_cmp++; if (acc_q.size() < 3 || acc_q[2] !== 32'h104) begin n_fail++; $display("FAIL redir_new_addr: got %h want 00000104", (acc_q.size() > 2) ? acc_q[2] : 32'hx); end
    n_cmp++; if (pop_pc.size() < 2) begin n_fail++; $display("FAIL redir_pop_count: got %0d want >=2", pop_pc.size()); end
    if (pop_pc.size() >= 2) begin
      n_cmp++; if (pop_pc[0] !== 32'h104) begin n_fail++; $display("FAIL redir_pc0: got %h want 00000104", pop_pc[0]); end
      n_cmp++; if (pop_inst[0] !== 32'hFFFF_FEFB) begin n_fail++; $display("FAIL redir_inst0: got %h want fffffefb", pop_inst[0]); end
      n_cmp++; if (pop_pc[1] !== 32'h108) begin n_fail++; $display("FAIL redir_pc1: got %h want 00000108", pop_pc[1]); end
    end
  endtask

  task automatic test_misaligned();
    do_reset(1, 1'b1, 1'b0);
    repeat (5) step();
    n_cmp++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL mis_buffered: got %b want 1", if_valid); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0203;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL mis_flush: got %b want 0", if_valid); end
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL mis_req_valid: got %b want 1", mem_req_valid); end
    n_cmp++; if (mem_req_addr !== 32'h200) begin n_fail++; $display("FAIL mis_req_addr: got %h want 00000200", mem_req_addr); end
    if_ready = 1'b1;
    repeat (10) step();
    n_cmp++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h200) begin n_fail++; $display("FAIL mis_pc0: got %h want 00000200", (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
    n_cmp++; if (pop_inst.size() < 1 || pop_inst[0] !== 32'hFFFF_FDFF) begin n_fail++; $display("FAIL mis_inst0: got %h want fffffdff", (pop_inst.size() > 0) ? pop_inst[0] : 32'hx); end
  endtask

  task automatic test_held_redirect();
    do_reset(1, 1'b0, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL held_a: got v=%b a=%h want v=1 a=00000000", mem_req_valid, mem_req_addr); end
    step();
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin n_fail++; $display("FAIL held_b: got v=%b a=%h want v=1 a=00000000", mem_req_valid, mem_req_addr); end
    mem_req_ready = 1'b1;
    step();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL held_drain_no_req: got %b want 0", mem_req_valid); end
    repeat (10) step();
    n_cmp++; if (acc_q.size() < 2 || acc_q[0] !== 32'h0 || acc_q[1] !== 32'h80) begin n_fail++; $display("FAIL held_accepts: got n=%0d a0=%h a1=%h want a0=00000000 a1=00000080", acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 32'hx, (acc_q.size() > 1) ? acc_q[1] : 32'hx); end
    n_cmp++; if (pop_pc.size() < 1 || pop_pc[0] !== 32'h80) begin n_fail++; $display("FAIL held_pc0: got %h want 00000080", (pop_pc.size() > 0) ? pop_pc[0] : 32'hx); end
  endtask

  task automatic test_wrap();
    do_reset(1, 1'b1, 1'b1);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    repeat (12) step();
    n_cmp++; if (acc_q.size() < 3 || acc_q[1] !== 32'hFFFF_FFFC || acc_q[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_addrs: got n=%0d a1=%h a2=%h want a1=fffffffc a2=00000000", acc_q.size(), (acc_q.size() > 1) ? acc_q[1] : 32'hx, (acc_q.size() > 2) ? acc_q[2] : 32'hx); end
    n_cmp++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'hFFFF_FFFC || pop_pc[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_pcs: got n=%0d p0=%h p1=%h want p0=fffffffc p1=00000000", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, (pop_pc.size() > 1) ? pop_pc[1] : 32'hx); end
    n_cmp++; if (pop_inst.size() < 2 || pop_inst[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_inst1: got %h want ffffffff", (pop_inst.size() > 1) ? pop_inst[1] : 32'hx); end
  endtask

  task automatic test_reset_mid();
    do_reset(1, 1'b1, 1'b0);
    repeat (2) step();
    n_cmp++; if (mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_req: got %b want 1", mem_req_valid); end
    rst = 1'b1;
    step();
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_req_valid: got %b want 0", mem_req_valid); end
    n_cmp++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_if_valid: got %b want 0", if_valid); end
    n_cmp++; if (if_pc !== 32'h0 || if_inst !== 32'h0) begin n_fail++; $display("FAIL rmid_head: got pc=%h inst=%h want 0/0", if_pc, if_inst); end
    clear_logs();
    rst = 1'b0;
    if_ready = 1'b1;
    repeat (12) step();
    n_cmp++; if (pop_pc.size() < 2 || pop_pc[0] !== 32'h0 || pop_pc[1] !== 32'h4) begin n_fail++; $display("FAIL rmid_restart: got n=%0d p0=%h p1=%h want 00000000 00000004", pop_pc.size(), (pop_pc.size() > 0) ? pop_pc[0] : 32'hx, (pop_pc.size() > 1) ? pop_pc[1] : 32'hx); end
    n_cmp++; if (pop_inst.size() < 2 || pop_inst[1] !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL rmid_inst1: got %h want fffffffb", (pop_inst.size() > 1) ? pop_inst[1] : 32'hx); end
  endtask

  initial begin
    #1;
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_held_redirect();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
